// File: rtl/txn_submit_arbiter.sv
// txn_submit_arbiter: round-robin arbiter that lets NUM_REQ transaction
// requesters share a single scheduler submit port. One transaction is in
// flight at a time. The granted payload is held in output registers until
// the requester has been answered with accepted, conflict or timeout.
module txn_submit_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DEP_W       = 65536,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*64-1:0]    req_programID,
  input  logic [NUM_REQ*DEP_W-1:0] req_read_deps,
  input  logic [NUM_REQ*DEP_W-1:0] req_write_deps,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [1:0]               resp_status,
  output logic [63:0]              resp_conflicting_id,
  output logic [63:0]              owner_programID,
  output logic [DEP_W-1:0]         read_dependencies,
  output logic [DEP_W-1:0]         write_dependencies,
  output logic                     transaction_valid,
  input  logic                     transaction_accepted,
  input  logic                     has_conflict,
  input  logic [63:0]              conflicting_id,
  output logic                     busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] STATUS_ACCEPTED = 2'b00;
  localparam logic [1:0] STATUS_CONFLICT = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_q;
  logic [CNT_W-1:0]   tmo_cnt;

  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;

  logic [63:0]        pid_arr  [NUM_REQ];
  logic [DEP_W-1:0]   rdep_arr [NUM_REQ];
  logic [DEP_W-1:0]   wdep_arr [NUM_REQ];

  // Index reached by stepping 'off' places past 'ptr', wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // One-hot requester mask used for the completion pulse.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Split the flattened request buses into per-requester slices.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign pid_arr[g]  = req_programID[g*64 +: 64];
    assign rdep_arr[g] = req_read_deps[g*DEP_W +: DEP_W];
    assign wdep_arr[g] = req_write_deps[g*DEP_W +: DEP_W];
  end

  // Round-robin pick: first requester at or after rr_ptr that is requesting.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[rr_idx(rr_ptr, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(rr_ptr, i);
      end
    end
  end

  // Submit FSM with registered payload, issue strobe, response and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      rr_ptr              <= '0;
      gnt_q               <= '0;
      tmo_cnt             <= '0;
      transaction_valid   <= 1'b0;
      resp_valid          <= '0;
      resp_status         <= STATUS_ACCEPTED;
      resp_conflicting_id <= '0;
      owner_programID     <= '0;
      read_dependencies   <= '0;
      write_dependencies  <= '0;
      busy                <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_found) begin
            gnt_q              <= gnt_idx;
            owner_programID    <= pid_arr[gnt_idx];
            read_dependencies  <= rdep_arr[gnt_idx];
            write_dependencies <= wdep_arr[gnt_idx];
            transaction_valid  <= 1'b1;
            busy               <= 1'b1;
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Strobes seen here belong to nothing we issued; ignore them.
          transaction_valid <= 1'b0;
          tmo_cnt           <= '0;
          state             <= ST_WAIT;
        end
        ST_WAIT: begin
          if (transaction_accepted) begin
            // Accepted wins over a simultaneous conflict report.
            resp_status <= STATUS_ACCEPTED;
            resp_valid  <= onehot(gnt_q);
            state       <= ST_RESP;
          end else if (has_conflict) begin
            resp_status         <= STATUS_CONFLICT;
            resp_conflicting_id <= conflicting_id;
            resp_valid          <= onehot(gnt_q);
            state               <= ST_RESP;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            resp_status <= STATUS_TIMEOUT;
            resp_valid  <= onehot(gnt_q);
            state       <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          resp_valid <= '0;
          rr_ptr     <= rr_idx(gnt_q, 1);
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_txn_submit_arbiter.sv
// tb_txn_submit_arbiter: directed vectors for the round-robin transaction
// submit arbiter with hand-computed expected values.
module tb_txn_submit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DEP_W   = 65536;
  localparam int TMO     = 64;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*64-1:0]    req_programID;
  logic [NUM_REQ*DEP_W-1:0] req_read_deps;
  logic [NUM_REQ*DEP_W-1:0] req_write_deps;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [1:0]               resp_status;
  logic [63:0]              resp_conflicting_id;
  logic [63:0]              owner_programID;
  logic [DEP_W-1:0]         read_dependencies;
  logic [DEP_W-1:0]         write_dependencies;
  logic                     transaction_valid;
  logic                     transaction_accepted;
  logic                     has_conflict;
  logic [63:0]              conflicting_id;
  logic                     busy;

  int n_chk = 0;
  int n_err = 0;

  txn_submit_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DEP_W       (DEP_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_programID        (req_programID),
    .req_read_deps        (req_read_deps),
    .req_write_deps       (req_write_deps),
    .resp_valid           (resp_valid),
    .resp_status          (resp_status),
    .resp_conflicting_id  (resp_conflicting_id),
    .owner_programID      (owner_programID),
    .read_dependencies    (read_dependencies),
    .write_dependencies   (write_dependencies),
    .transaction_valid    (transaction_valid),
    .transaction_accepted (transaction_accepted),
    .has_conflict         (has_conflict),
    .conflicting_id       (conflicting_id),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the design stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tv(input int max, output int n);
    n = 0;
    while (!transaction_valid && n < max) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_resp(input int max, output int n);
    n = 0;
    while (resp_valid == '0 && n < max) begin
      step(1);
      n++;
    end
  endtask

  int n;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n                = 1'b0;
    req_valid            = '0;
    req_programID        = '0;
    req_read_deps        = '0;
    req_write_deps       = '0;
    transaction_accepted = 1'b0;
    has_conflict         = 1'b0;
    conflicting_id       = '0;
    step(2);

    // Reset state
    chk("rst_tv",     64'(transaction_valid), 64'd0);
    chk("rst_resp",   64'(resp_valid), 64'd0);
    chk("rst_status", 64'(resp_status), 64'd0);
    chk("rst_cid",    resp_conflicting_id, 64'd0);
    chk("rst_owner",  owner_programID, 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    rst_n = 1'b1;
    step(1);

    // All requesters held, scheduler always accepting: order 0,1,2,3,0
    for (int i = 0; i < NUM_REQ; i++) req_programID[i*64 +: 64] = 64'h10 + 64'(i);
    req_valid            = 4'b1111;
    transaction_accepted = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_tv(8, n);
      chk("rr_tv_lat", 64'(n), (k == 0) ? 64'd1 : 64'd2);
      chk("rr_owner", owner_programID, 64'h10 + 64'(order[k]));
      if (k == 4) req_valid = '0;
      step(1);
      chk("rr_tv_pulse", 64'(transaction_valid), 64'd0);
      wait_resp(8, n);
      chk("rr_resp_lat", 64'(n), 64'd1);
      chk("rr_resp_vld", 64'(resp_valid), 64'd1 << order[k]);
    end
    step(1);
    transaction_accepted = 1'b0;
    chk("rr_idle_busy", 64'(busy), 64'd0);

    // Requester 0, ID 1, write dep entry 2 = 5, accepted 3 cycles after issue
    req_programID                 = '0;
    req_programID[63:0]           = 64'd1;
    req_write_deps[0*DEP_W + 128 +: 64] = 64'd5;
    req_valid                     = 4'b0001;
    wait_tv(8, n);
    chk("s1_tv_lat", 64'(n), 64'd1);
    chk("s1_owner", owner_programID, 64'd1);
    chk("s1_wdep2", write_dependencies[128 +: 64], 64'd5);
    chk("s1_busy", 64'(busy), 64'd1);
    req_valid                     = '0;
    req_programID[63:0]           = 64'hFF;
    req_write_deps[0*DEP_W + 128 +: 64] = 64'd0;
    step(1);
    chk("s1_tv_pulse", 64'(transaction_valid), 64'd0);
    chk("s1_no_early_resp", 64'(resp_valid), 64'd0);
    step(1);
    chk("s1_no_early_resp2", 64'(resp_valid), 64'd0);
    chk("s1_owner_hold", owner_programID, 64'd1);
    transaction_accepted = 1'b1;
    step(1);
    transaction_accepted = 1'b0;
    chk("s1_resp_vld", 64'(resp_valid), 64'b0001);
    chk("s1_status", 64'(resp_status), 64'd0);
    chk("s1_owner_resp", owner_programID, 64'd1);
    chk("s1_wdep2_hold", write_dependencies[128 +: 64], 64'd5);
    step(1);
    chk("s1_resp_pulse", 64'(resp_valid), 64'd0);
    chk("s1_busy_done", 64'(busy), 64'd0);
    chk("s1_no_regrant", 64'(transaction_valid), 64'd0);

    // Requester 2, ID 2, read dep = 5, conflict with ID 1
    req_programID[2*64 +: 64]   = 64'd2;
    req_read_deps[2*DEP_W +: 64] = 64'd5;
    req_valid                   = 4'b0100;
    wait_tv(8, n);
    chk("s3_tv_lat", 64'(n), 64'd1);
    chk("s3_owner", owner_programID, 64'd2);
    chk("s3_rdep0", read_dependencies[63:0], 64'd5);
    step(1);
    has_conflict   = 1'b1;
    conflicting_id = 64'd1;
    step(1);
    has_conflict   = 1'b0;
    conflicting_id = 64'd0;
    req_valid      = '0;
    chk("s3_resp_vld", 64'(resp_valid), 64'b0100);
    chk("s3_status", 64'(resp_status), 64'd1);
    chk("s3_cid", resp_conflicting_id, 64'd1);
    step(1);
    chk("s3_resp_pulse", 64'(resp_valid), 64'd0);

    // Strobes in IDLE are ignored
    transaction_accepted = 1'b1;
    has_conflict         = 1'b1;
    step(1);
    transaction_accepted = 1'b0;
    has_conflict         = 1'b0;
    chk("idle_strobe_resp", 64'(resp_valid), 64'd0);
    chk("idle_strobe_busy", 64'(busy), 64'd0);

    // Requester 1 timeout; a strobe during ISSUE must be ignored
    req_programID[1*64 +: 64] = 64'd7;
    req_valid                 = 4'b0010;
    wait_tv(8, n);
    chk("s4_tv_lat", 64'(n), 64'd1);
    chk("s4_owner", owner_programID, 64'd7);
    transaction_accepted = 1'b1;
    step(1);
    transaction_accepted = 1'b0;
    req_valid            = '0;
    wait_resp(TMO + 20, n);
    chk("s4_tmo_lat", 64'(n + 1), 64'(TMO + 1));
    chk("s4_resp_vld", 64'(resp_valid), 64'b0010);
    chk("s4_status", 64'(resp_status), 64'd2);
    step(1);
    chk("s4_resp_pulse", 64'(resp_valid), 64'd0);
    chk("s4_busy_done", 64'(busy), 64'd0);

    // Accepted and conflict together: accepted wins
    req_programID[2*64 +: 64] = 64'h33;
    req_valid                 = 4'b0100;
    wait_tv(8, n);
    chk("s5_tv_lat", 64'(n), 64'd1);
    step(1);
    transaction_accepted = 1'b1;
    has_conflict         = 1'b1;
    conflicting_id       = 64'd9;
    step(1);
    transaction_accepted = 1'b0;
    has_conflict         = 1'b0;
    conflicting_id       = 64'd0;
    req_valid            = '0;
    chk("s5_resp_vld", 64'(resp_valid), 64'b0100);
    chk("s5_status", 64'(resp_status), 64'd0);
    step(1);

    // Reset during WAIT for requester 3 abandons the transaction
    req_programID[3*64 +: 64] = 64'h44;
    req_valid                 = 4'b1000;
    wait_tv(8, n);
    chk("s6_tv_lat", 64'(n), 64'd1);
    chk("s6_owner", owner_programID, 64'h44);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_tv", 64'(transaction_valid), 64'd0);
    chk("s6_rst_resp", 64'(resp_valid), 64'd0);
    chk("s6_rst_busy", 64'(busy), 64'd0);
    chk("s6_rst_status", 64'(resp_status), 64'd0);
    chk("s6_rst_owner", owner_programID, 64'd0);
    chk("s6_rst_rdep", 64'(|read_dependencies), 64'd0);
    req_programID[1*64 +: 64] = 64'h11;
    req_valid                 = 4'b1010;
    step(1);
    chk("s6_rst_hold_resp", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    wait_tv(8, n);
    chk("s6_regrant_lat", 64'(n), 64'd1);
    chk("s6_regrant_owner", owner_programID, 64'h11);
    req_valid = '0;
    step(1);
    transaction_accepted = 1'b1;
    step(1);
    transaction_accepted = 1'b0;
    chk("s6_regrant_resp", 64'(resp_valid), 64'b0010);
    step(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/txn_submit_arbiter.md
TXN_SUBMIT_ARBITER -- requirements
Module: txn_submit_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of transaction requesters sharing one scheduler input port.
REQ-002 Parameter DEP_W, 65536, width of each flattened dependency bundle (1024 x 64-bit entries).
REQ-003 Parameter TIMEOUT_CYC, 64, maximum cycles WAIT may last before a timeout response.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester request; held high until its own resp_valid.
REQ-007 req_programID  input  NUM_REQ*64  per-requester owner program ID, slice i = [i*64 +: 64].
REQ-008 req_read_deps / req_write_deps  input  NUM_REQ*DEP_W each  per-requester dependency bundles.
REQ-009 resp_valid  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-010 resp_status  output  2  00 accepted, 01 conflict, 10 timeout; valid with any resp_valid bit.
REQ-011 resp_conflicting_id  output  64  conflicting transaction ID; valid when resp_status = 01.
REQ-012 owner_programID / read_dependencies / write_dependencies  output  64 / DEP_W / DEP_W  registered payload to the scheduler.
REQ-013 transaction_valid  output  1  one-cycle issue pulse to the scheduler.
REQ-014 transaction_accepted, has_conflict  input  1 each  scheduler result strobes; conflicting_id  input  64.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP shall be encoded in 2 bits.
REQ-017 IDLE: if any req_valid bit is set, grant round-robin starting at rr_ptr; latch the granted index and its payload into the output registers; go to ISSUE next cycle.
REQ-018 ISSUE: drive transaction_valid = 1 for exactly one cycle; clear the timeout counter; go to WAIT.
REQ-019 WAIT: on transaction_accepted, status 00; otherwise on has_conflict, status 01 with conflicting_id latched; either event goes to RESP.
REQ-020 If transaction_accepted and has_conflict are sampled high together, accepted shall win (status 00).
REQ-021 Strobes arriving in IDLE, ISSUE or RESP shall be ignored.
REQ-022 WAIT: the counter increments each cycle; when it reaches TIMEOUT_CYC-1 with no strobe, status 10; go to RESP.
REQ-023 RESP: pulse resp_valid[granted] for one cycle with status and ID; set rr_ptr = granted+1 modulo NUM_REQ; go to IDLE.
REQ-024 Grant-to-transaction_valid latency shall be 1 cycle; strobe-to-resp_valid latency 1 cycle; minimum request turnaround 4 cycles.
REQ-025 Payload outputs shall stay stable from ISSUE until leaving RESP, regardless of req_* changes.
REQ-026 If the granted requester drops req_valid mid-transaction, the transaction completes and the resp_valid pulse is still issued.
REQ-027 A requester still holding req_valid in the cycle after its resp_valid shall be treated as a new request.
REQ-028 With all NUM_REQ requesting continuously, each shall be served once per NUM_REQ grants.

Reset
REQ-029 rst_n low shall asynchronously force: state IDLE, rr_ptr 0, transaction_valid 0, resp_valid 0, resp_status 00, resp_conflicting_id 0, payload registers 0, timeout counter 0, busy 0.
REQ-030 Reset asserted mid-WAIT shall abandon the transaction with no resp_valid; after release, arbitration restarts from requester 0.

Verification
REQ-031 req_valid=0001, ID 1, write dep entry 2 = 5; scheduler accepts 3 cycles after issue -> transaction_valid one pulse, resp_valid=0001, status 00.
REQ-032 req_valid=1111 held, scheduler always accepts -> grant order 0,1,2,3,0, each on its own transaction_valid pulse.
REQ-033 Requester 2, ID 2, read dep = 5; scheduler returns has_conflict with conflicting_id=1 -> resp_valid=0100, status 01, resp_conflicting_id=1.
REQ-034 No scheduler strobe after issue -> resp_valid exactly TIMEOUT_CYC+1 cycles after transaction_valid, status 10.
REQ-035 transaction_accepted and has_conflict high in the same cycle -> status 00.
REQ-036 rst_n pulsed low during WAIT for requester 3 -> no resp_valid, all outputs 0; the next grant goes to the lowest requesting index.
